otg_hpi_master: RTL
===================

# otg_hpi_master

Hardware HPI host controller for the CY7C67200 USB OTG port. It replaces the software bit-banged data/address/strobe PIO path. The Nios issues one Avalon-MM read or write per HPI register access. The block sequences the chip-select, read, write, address and data-direction pins with parameterised setup, strobe, hold and recovery times. It sits between the Avalon interconnect and the top-level OTG pins, and the tristate buffer is in the top level.

## Interface
- SETUP_CYC, default 1: clk cycles from cs_n/addr/data valid to the strobe falling edge; must be ≥1.
- STROBE_CYC, default 3: clk cycles with r_n/w_n low; must be ≥1.
- HOLD_CYC, default 1: clk cycles after the strobe rises with cs_n, addr and data held; must be ≥1.
- RECOVER_CYC, default 2: idle clk cycles between accesses; must be ≥1.
- Any parameter equal to 0 is an elaboration error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  16  write data.
- readdata  out  16  read data, registered.
- waitrequest  out  1  Avalon stall.
- otg_hpi_addr  out  2  HPI address pins.
- otg_hpi_cs_n  out  1  chip select, active-low.
- otg_hpi_r_n  out  1  read strobe, active-low.
- otg_hpi_w_n  out  1  write strobe, active-low.
- otg_hpi_data_out  out  16  data driven to the pins.
- otg_hpi_data_oe  out  1  data output enable, high means drive.
- otg_hpi_data_in  in  16  data sampled from the pins.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE. A single down-counter is loaded with (N−1) on entry to each state.
- IDLE, read|write high:
  - Latch address, direction and writedata.
  - Go to SETUP.
  - If read and write are both high, the write wins.
- Latched values are used for the whole access. Changes on the Avalon inputs after the request is accepted are ignored.
- cs_n is low in SETUP, STROBE and HOLD, and high otherwise.
- otg_hpi_addr is driven from the latched address in those same states and holds its last value otherwise.
- r_n (read) or w_n (write) is low only in STROBE.
- For a write, otg_hpi_data_oe is high in SETUP, STROBE and HOLD, and otg_hpi_data_out carries the latched writedata. For a read, data_oe stays low.
- For a read, otg_hpi_data_in is captured into readdata on the last STROBE cycle, at the clock edge where r_n is about to rise.
- done is high for exactly one cycle, the last HOLD cycle.
- waitrequest = (read|write) & ~done. Avalon completes the transfer in the done cycle, and readdata is valid in that cycle.
- Requests that arrive during RECOVER see waitrequest high. They are accepted when the FSM reaches IDLE.
- readdata holds its value until the next read capture.

## Timing
- Reset values:
  - readdata = 0, otg_hpi_addr = 0, otg_hpi_data_out = 0.
  - cs_n, r_n, w_n = 1.
  - data_oe = 0, busy = 0, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-access immediately releases all strobes and data_oe. The access is abandoned and no done is generated.
- Request accepted in cycle 0 (IDLE):
  - SETUP occupies cycles 1..S.
  - STROBE occupies S+1..S+T.
  - HOLD occupies S+T+1..S+T+H.
  - done and waitrequest low in cycle S+T+H.
- With defaults: done in cycle 5, RECOVER in cycles 6–7, IDLE in cycle 8.
- Back-to-back access period = 1+S+T+H+R cycles (8 with defaults).
- All outputs are registered except waitrequest, which is combinational from read/write and done.

## Structure
- Package otg_hpi_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - the register index constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3.
- The design is a single module with no sub-module. The timing counter is 8 bits wide and lives inline.

## Test plan
- Reset check: hold reset_n low → cs_n=r_n=w_n=1, data_oe=0, readdata=0, waitrequest=read|write.
- Write, defaults: write address=2, data=0x1234 at cycle 0 →
  - cs_n low cycles 1–5, w_n low cycles 2–4, data_oe high cycles 1–5;
  - data_out=0x1234, addr=2;
  - waitrequest low only in cycle 5.
- Read, defaults: read address=0 with data_in=0xBEEF during strobe → r_n low cycles 2–4, readdata=0xBEEF in cycle 5, data_oe never high.
- Back-to-back: write then read issued immediately → second access starts its SETUP at cycle 9, strobes never overlap, cs_n high for cycles 6–8.
- Mid-access reset: assert reset_n low in cycle 3 of a write → w_n, cs_n and data_oe deassert asynchronously; after release the FSM is in IDLE and no done occurs.
- Parameter sweep and conflict: SETUP=2, STROBE=5, HOLD=3, RECOVER=1 → done at cycle 10. Read and write both high → a write cycle executes.

Source files
------------

// File: rtl/otg_hpi_pkg.sv
// Shared FSM state type, HPI register indices and timing-counter helpers
// for the CY7C67200 HPI host controller.
package otg_hpi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RECOVER
   } hpi_state_t;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   // A phase lasting n cycles is counted down from n-1 to zero.
   function automatic cnt_t cyc_load(input int n);
      return cnt_t'(n - 1);
   endfunction

endpackage

// File: rtl/otg_hpi_master.sv
// Avalon-MM slave that runs one timed HPI pin access per request:
// chip-select/address/data setup, strobe, hold, then recovery.
module otg_hpi_master
   import otg_hpi_pkg::*;
#(
   parameter int SETUP_CYC   = 1,
   parameter int STROBE_CYC  = 3,
   parameter int HOLD_CYC    = 1,
   parameter int RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        waitrequest,
   output logic [1:0]  otg_hpi_addr,
   output logic        otg_hpi_cs_n,
   output logic        otg_hpi_r_n,
   output logic        otg_hpi_w_n,
   output logic [15:0] otg_hpi_data_out,
   output logic        otg_hpi_data_oe,
   input  logic [15:0] otg_hpi_data_in,
   output logic        busy
);

   if (SETUP_CYC < 1 || SETUP_CYC > 256 || STROBE_CYC < 1 || STROBE_CYC > 256 ||
       HOLD_CYC < 1 || HOLD_CYC > 256 || RECOVER_CYC < 1 || RECOVER_CYC > 256)
   begin : g_param_check
      $error("otg_hpi_master: every timing parameter must lie in 1..256");
   end

   localparam cnt_t SETUP_LD   = cyc_load(SETUP_CYC);
   localparam cnt_t STROBE_LD  = cyc_load(STROBE_CYC);
   localparam cnt_t HOLD_LD    = cyc_load(HOLD_CYC);
   localparam cnt_t RECOVER_LD = cyc_load(RECOVER_CYC);

   hpi_state_t  state, state_nx;
   cnt_t        cnt, cnt_nx;
   logic        accept;
   logic        done;
   logic        last_strobe;
   logic        active_nx;
   logic        is_wr, is_wr_nx;
   logic [1:0]  addr_q, addr_nx;
   logic [15:0] wdata_q, wdata_nx;

   always_comb begin
      // NOTE: every signal of this block gets a default first, so no latch is inferred.
      state_nx = state;
      cnt_nx   = (cnt == '0) ? '0 : cnt - cnt_t'(1);
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (read | write) begin
               accept   = 1'b1;
               state_nx = SETUP;
               cnt_nx   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nx = STROBE;
               cnt_nx   = STROBE_LD;
            end
         end
         STROBE: begin
            if (cnt == '0) begin
               state_nx = HOLD;
               cnt_nx   = HOLD_LD;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nx = RECOVER;
               cnt_nx   = RECOVER_LD;
            end
         end
         RECOVER: begin
            if (cnt == '0) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request fields are captured once at acceptance; a simultaneous read and write runs as a write.
   assign is_wr_nx  = accept ? write     : is_wr;
   assign addr_nx   = accept ? address   : addr_q;
   assign wdata_nx  = accept ? writedata : wdata_q;
   assign active_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);

   assign done        = (state == HOLD) && (cnt == '0);
   assign last_strobe = (state == STROBE) && (cnt == '0);
   assign waitrequest = (read | write) & ~done;

   // NOTE: state uses non-blocking assignments only; pins are decoded from the next
   // state and registered, so they switch cleanly on the clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         cnt              <= '0;
         is_wr            <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         readdata         <= '0;
         otg_hpi_addr     <= '0;
         otg_hpi_data_out <= '0;
         otg_hpi_cs_n     <= 1'b1;
         otg_hpi_r_n      <= 1'b1;
         otg_hpi_w_n      <= 1'b1;
         otg_hpi_data_oe  <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         is_wr           <= is_wr_nx;
         addr_q          <= addr_nx;
         wdata_q         <= wdata_nx;
         otg_hpi_cs_n    <= ~active_nx;
         otg_hpi_r_n     <= ~((state_nx == STROBE) && !is_wr_nx);
         otg_hpi_w_n     <= ~((state_nx == STROBE) && is_wr_nx);
         otg_hpi_data_oe <= active_nx && is_wr_nx;
         busy            <= (state_nx != IDLE);
         if (active_nx) begin
            otg_hpi_addr <= addr_nx;
         end
         if (active_nx && is_wr_nx) begin
            otg_hpi_data_out <= wdata_nx;
         end
         if (last_strobe && !is_wr) begin
            readdata <= otg_hpi_data_in;
         end
      end
   end

endmodule
